sfp_link_supervisor: RTL and testbench

- Multi-channel SFP link supervisor in the sysclk_100m domain, placed between the per-channel PCS/PMA cores and the board status LEDs.
- Per channel it synchronises the raw link-status bit and debounces link-up.
- It counts link drops and issues a timed per-channel reset when a link stays down too long.
- It drives a parametrised LED bank with per-channel and heartbeat indications, generalising the fixed 2-SFP / 4-LED test top.

---
 rtl/sfp_sup_pkg.sv | 31 +++
 rtl/sfp_link_chan.sv | 156 +++++++++++++++
 rtl/sfp_link_supervisor.sv | 94 +++++++++
 tb/tb_sfp_link_supervisor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_sup_pkg.sv
// Shared types and helpers for the SFP link supervisor: link state encoding,
// timer width helper and LED pattern constants.
package sfp_sup_pkg;

  typedef enum logic [1:0] {DOWN, QUAL, UP, RST} link_state_t;

  localparam logic LED_OFF = 1'b0;
  localparam logic LED_ON  = 1'b1;

  // Width needed to count up to max(a,b,c)-1, never less than one bit.
  function automatic int clog2max(input int a, input int b, input int c);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic led_for_state(input link_state_t st, input logic blink);
    logic led;
    case (st)
      UP:      led = LED_ON;
      QUAL:    led = blink;
      DOWN:    led = LED_OFF;
      RST:     led = LED_ON;
      default: led = LED_OFF;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/sfp_link_chan.sv
// One supervised SFP channel: link-status synchroniser, DOWN/QUAL/UP/RST FSM
// with a shared timer, and a saturating link-drop counter.
module sfp_link_chan
  import sfp_sup_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int RETRY_CYCLES       = 200000000,
  parameter int RESET_PULSE_CYCLES = 1000,
  parameter int DROP_CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  link_raw,
  input  logic                  drop_clr,
  output logic                  link_ok,
  output logic                  ch_reset,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output link_state_t           state
);

  localparam int TIMER_W = clog2max(DEBOUNCE_CYCLES, RETRY_CYCLES, RESET_PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1'b1);
  localparam logic [TIMER_W-1:0] DEB_LAST   = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RETRY_LAST = TIMER_W'(RETRY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_ZERO = {DROP_CNT_W{1'b0}};
  localparam logic [DROP_CNT_W-1:0] DROP_ONE  = DROP_CNT_W'(1'b1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = {DROP_CNT_W{1'b1}};

  logic [1:0]            sync_r;
  logic                  link_s;
  link_state_t           state_r, state_next_s;
  logic [TIMER_W-1:0]    timer_r, timer_next_s;
  logic                  drop_inc_s;
  logic                  link_ok_s, ch_reset_s;
  logic                  link_ok_r, ch_reset_r;
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  // Two-flop synchroniser for the asynchronous PCS/PMA link status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], link_raw};
    end
  end

  assign link_s = sync_r[1];

  // FSM state and timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DOWN;
      timer_r <= TIMER_ZERO;
    end else begin
      state_r <= state_next_s;
      timer_r <= timer_next_s;
    end
  end

  // Next-state and timer logic; a rising link in DOWN beats the retry expiry.
  always_comb begin
    state_next_s = state_r;
    timer_next_s = timer_r + TIMER_ONE;
    drop_inc_s   = 1'b0;
    case (state_r)
      DOWN: begin
        if (link_s) begin
          state_next_s = QUAL;
          timer_next_s = TIMER_ZERO;
        end else if (timer_r == RETRY_LAST) begin
          state_next_s = RST;
          timer_next_s = TIMER_ZERO;
        end else begin
          state_next_s = DOWN;
        end
      end
      QUAL: begin
        if (!link_s) begin
          state_next_s = DOWN;
          timer_next_s = TIMER_ZERO;
        end else if (timer_r == DEB_LAST) begin
          state_next_s = UP;
          timer_next_s = TIMER_ZERO;
        end else begin
          state_next_s = QUAL;
        end
      end
      UP: begin
        timer_next_s = TIMER_ZERO;
        if (!link_s) begin
          state_next_s = DOWN;
          drop_inc_s   = 1'b1;
        end else begin
          state_next_s = UP;
        end
      end
      RST: begin
        if (timer_r == PULSE_LAST) begin
          state_next_s = DOWN;
          timer_next_s = TIMER_ZERO;
        end else begin
          state_next_s = RST;
        end
      end
      default: begin
        state_next_s = DOWN;
        timer_next_s = TIMER_ZERO;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    link_ok_s  = 1'b0;
    ch_reset_s = 1'b0;
    case (state_r)
      UP:      link_ok_s  = 1'b1;
      RST:     ch_reset_s = 1'b1;
      DOWN:    link_ok_s  = 1'b0;
      QUAL:    link_ok_s  = 1'b0;
      default: link_ok_s  = 1'b0;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_ok_r  <= 1'b0;
      ch_reset_r <= 1'b0;
    end else begin
      link_ok_r  <= link_ok_s;
      ch_reset_r <= ch_reset_s;
    end
  end

  // Saturating drop counter; a clear overrides a simultaneous drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= DROP_ZERO;
    end else if (drop_clr) begin
      drop_cnt_r <= DROP_ZERO;
    end else if (drop_inc_s && (drop_cnt_r != DROP_MAX)) begin
      drop_cnt_r <= drop_cnt_r + DROP_ONE;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign link_ok  = link_ok_r;
  assign ch_reset = ch_reset_r;
  assign drop_cnt = drop_cnt_r;
  assign state    = state_r;

endmodule

// File: rtl/sfp_link_supervisor.sv
// Multi-channel SFP link supervisor: per-channel link qualification and retry
// resets, plus a status LED bank with a shared blink/heartbeat timebase.
module sfp_link_supervisor
  import sfp_sup_pkg::*;
#(
  parameter int SFP_COUNT          = 2,
  parameter int LED_COUNT          = 4,
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int RETRY_CYCLES       = 200000000,
  parameter int RESET_PULSE_CYCLES = 1000,
  parameter int BLINK_CYCLES       = 25000000,
  parameter int DROP_CNT_W         = 16
) (
  input  logic                             sysclk_100m,
  input  logic                             sys_reset_n,
  input  logic [SFP_COUNT-1:0]             link_up_in,
  input  logic                             drop_clr_in,
  output logic [SFP_COUNT-1:0]             link_ok_out,
  output logic                             all_up_out,
  output logic [SFP_COUNT-1:0]             ch_reset_out,
  output logic [SFP_COUNT*DROP_CNT_W-1:0]  drop_cnt_out,
  output logic [LED_COUNT-1:0]             sleds
);

  // The top LED is always the heartbeat, so at most LED_COUNT-1 channels get one.
  localparam int LED_CH  = (SFP_COUNT < LED_COUNT - 1) ? SFP_COUNT : LED_COUNT - 1;
  localparam int BLINK_W = clog2max(BLINK_CYCLES, 1, 1);
  localparam logic [BLINK_W-1:0] BLINK_ZERO = {BLINK_W{1'b0}};
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1'b1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  link_state_t          chan_state_s [SFP_COUNT];
  logic [BLINK_W-1:0]   blink_cnt_r;
  logic                 toggle_r;
  logic                 all_up_r;
  logic [LED_COUNT-1:0] led_next_s;
  logic [LED_COUNT-1:0] sleds_r;

  for (genvar i = 0; i < SFP_COUNT; i++) begin : g_chan
    sfp_link_chan #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .RETRY_CYCLES       (RETRY_CYCLES),
      .RESET_PULSE_CYCLES (RESET_PULSE_CYCLES),
      .DROP_CNT_W         (DROP_CNT_W)
    ) u_chan (
      .clk      (sysclk_100m),
      .rst_n    (sys_reset_n),
      .link_raw (link_up_in[i]),
      .drop_clr (drop_clr_in),
      .link_ok  (link_ok_out[i]),
      .ch_reset (ch_reset_out[i]),
      .drop_cnt (drop_cnt_out[i*DROP_CNT_W +: DROP_CNT_W]),
      .state    (chan_state_s[i])
    );
  end

  // Free-running blink/heartbeat timebase.
  always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      blink_cnt_r <= BLINK_ZERO;
      toggle_r    <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= BLINK_ZERO;
      toggle_r    <= ~toggle_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_ONE;
      toggle_r    <= toggle_r;
    end
  end

  // LED pattern per channel state, heartbeat on the top LED.
  always_comb begin
    led_next_s = {LED_COUNT{1'b0}};
    for (int i = 0; i < LED_CH; i++) begin
      led_next_s[i] = led_for_state(chan_state_s[i], toggle_r);
    end
    led_next_s[LED_COUNT-1] = toggle_r;
  end

  // Registered LED bank and aggregate link status.
  always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      sleds_r  <= {LED_COUNT{1'b0}};
      all_up_r <= 1'b0;
    end else begin
      sleds_r  <= led_next_s;
      all_up_r <= &link_ok_out;
    end
  end

  assign sleds      = sleds_r;
  assign all_up_out = all_up_r;

endmodule

// File: tb/tb_sfp_link_supervisor.sv
// Directed plus randomized bench for sfp_link_supervisor against a
// timestamp-based reference model of the link supervision rules.
module tb_sfp_link_supervisor;

  localparam int SFP      = 3;
  localparam int LEDS     = 3;
  localparam int DEB      = 8;
  localparam int RETRY    = 64;
  localparam int PULSE    = 4;
  localparam int BLINK    = 4;
  localparam int DW       = 2;
  localparam int DROP_SAT = (1 << DW) - 1;

  localparam int LINK_LOST   = 10;
  localparam int LINK_TRYING = 11;
  localparam int LINK_GOOD   = 12;
  localparam int LINK_KICKED = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SFP-1:0]    link_in;
  logic              clr;
  logic [SFP-1:0]    link_ok;
  logic              all_up;
  logic [SFP-1:0]    ch_reset;
  logic [SFP*DW-1:0] drop_cnt;
  logic [LEDS-1:0]   sleds;

  sfp_link_supervisor #(
    .SFP_COUNT(SFP), .LED_COUNT(LEDS), .DEBOUNCE_CYCLES(DEB), .RETRY_CYCLES(RETRY),
    .RESET_PULSE_CYCLES(PULSE), .BLINK_CYCLES(BLINK), .DROP_CNT_W(DW)
  ) dut (
    .sysclk_100m(clk), .sys_reset_n(rst_n), .link_up_in(link_in), .drop_clr_in(clr),
    .link_ok_out(link_ok), .all_up_out(all_up), .ch_reset_out(ch_reset),
    .drop_cnt_out(drop_cnt), .sleds(sleds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode per channel plus the edge index at which it was entered.
  int m_mode  [SFP];
  int m_since [SFP];
  int m_drop  [SFP];
  bit m_s1    [SFP];
  bit m_s2    [SFP];
  int k;
  logic [SFP-1:0]    m_ok_last;
  logic [SFP-1:0]    e_ok, e_rst;
  logic              e_all;
  logic [LEDS-1:0]   e_leds;
  logic [SFP*DW-1:0] e_drop;

  bit   mon_ch2;
  int   last_rise, rise_cnt;
  logic prev_r2;
  int   exp_seq [5] = '{1, 2, 3, 3, 3};
  int   hold [SFP];
  int   n;
  logic [7:0] hb_bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < SFP; c++) begin
      m_mode[c] = LINK_LOST; m_since[c] = 0; m_drop[c] = 0; m_s1[c] = 1'b0; m_s2[c] = 1'b0;
    end
    k = 0; m_ok_last = '0; e_ok = '0; e_rst = '0; e_all = 1'b0; e_leds = '0; e_drop = '0;
  endtask

  task automatic model_edge();
    bit blink_prev;
    bit ls;
    int el;
    k++;
    blink_prev = (((k - 1) / BLINK) % 2) == 1;
    e_all  = &m_ok_last;
    e_leds = '0;
    for (int c = 0; c < SFP; c++) begin
      e_ok[c]  = (m_mode[c] == LINK_GOOD);
      e_rst[c] = (m_mode[c] == LINK_KICKED);
      if (c < LEDS - 1)
        e_leds[c] = (m_mode[c] == LINK_GOOD || m_mode[c] == LINK_KICKED) ? 1'b1 :
                    (m_mode[c] == LINK_TRYING) ? blink_prev : 1'b0;
    end
    e_leds[LEDS-1] = blink_prev;
    m_ok_last = e_ok;
    for (int c = 0; c < SFP; c++) begin
      ls = m_s2[c];
      el = (k - 1) - m_since[c];
      case (m_mode[c])
        LINK_LOST:
          if (ls) begin m_mode[c] = LINK_TRYING; m_since[c] = k; end
          else if (el == RETRY - 1) begin m_mode[c] = LINK_KICKED; m_since[c] = k; end
        LINK_TRYING:
          if (!ls) begin m_mode[c] = LINK_LOST; m_since[c] = k; end
          else if (el == DEB - 1) begin m_mode[c] = LINK_GOOD; m_since[c] = k; end
        LINK_GOOD:
          if (!ls) begin
            m_mode[c] = LINK_LOST; m_since[c] = k;
            if (m_drop[c] < DROP_SAT) m_drop[c]++;
          end
        LINK_KICKED:
          if (el == PULSE - 1) begin m_mode[c] = LINK_LOST; m_since[c] = k; end
        default: ;
      endcase
      if (clr) m_drop[c] = 0;
      m_s2[c] = m_s1[c];
      m_s1[c] = link_in[c];
      e_drop[c*DW +: DW] = DW'(m_drop[c]);
    end
  endtask

  task automatic compare_all();
    check("link_ok", 32'(link_ok), 32'(e_ok));
    check("ch_reset", 32'(ch_reset), 32'(e_rst));
    check("all_up", 32'(all_up), 32'(e_all));
    check("drop_cnt", 32'(drop_cnt), 32'(e_drop));
    check("sleds", 32'(sleds), 32'(e_leds));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    compare_all();
    if (mon_ch2) begin
      if (ch_reset[2] && !prev_r2) begin
        if (last_rise >= 0) check("t3_period", k - last_rise, RETRY + PULSE);
        last_rise = k;
        rise_cnt++;
      end
      if (!ch_reset[2] && prev_r2) check("t3_width", k - last_rise, PULSE);
    end
    prev_r2 = ch_reset[2];
    @(negedge clk);
  endtask

  task automatic apply_reset_now();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; link_in = '0; clr = 1'b0;
    mon_ch2 = 1'b0; last_rise = -1; rise_cnt = 0; prev_r2 = 1'b0;
    model_reset();
    repeat (3) tick();

    // Test 1: release reset, bring channel 0 up.
    rst_n = 1'b1; mon_ch2 = 1'b1;
    link_in = 3'b001;
    tick();
    n = 0;
    while (n < 40 && link_ok[0] !== 1'b1) begin tick(); n++; end
    check("t1_rise_latency", n, DEB + 3);
    check("t1_all_up_low", 32'(all_up), 32'd0);
    repeat (2) tick();
    check("t1_led0_steady", 32'(sleds[0]), 32'd1);

    // Test 2: short pulse on channel 1 never qualifies.
    link_in[1] = 1'b1;
    repeat (5) tick();
    link_in[1] = 1'b0;
    repeat (20) tick();
    check("t2_link1_down", 32'(link_ok[1]), 32'd0);
    check("t2_drop1", 32'(drop_cnt[2*DW-1:DW]), 32'd0);

    // Test 3: channel 2 held low issues periodic reset pulses.
    n = 0;
    while (n < 400 && rise_cnt < 3) begin tick(); n++; end
    repeat (6) tick();
    check("t3_pulses_seen", 32'(rise_cnt >= 3), 32'd1);

    // Test 4: five drops on channel 0 saturate the counter.
    for (int j = 0; j < 5; j++) begin
      link_in[0] = 1'b0;
      repeat (4) tick();
      link_in[0] = 1'b1;
      repeat (16) tick();
      check("t4_drop0", 32'(drop_cnt[DW-1:0]), 32'(exp_seq[j]));
    end

    // Test 5: clear alone, then clear coinciding with a drop.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clear", 32'(drop_cnt[DW-1:0]), 32'd0);
    link_in[0] = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clear_wins", 32'(drop_cnt[DW-1:0]), 32'd0);
    link_in[0] = 1'b1;
    repeat (16) tick();
    check("t5_drop0_after", 32'(drop_cnt[DW-1:0]), 32'd0);

    // Test 6: all channels up, then reset in the middle of a channel reset pulse.
    mon_ch2 = 1'b0;
    link_in = 3'b111;
    n = 0;
    while (n < 120 && link_ok !== 3'b111) begin tick(); n++; end
    check("t6_all_links", 32'(link_ok), 32'h7);
    check("t6_all_up_lag", 32'(all_up), 32'd0);
    tick();
    check("t6_all_up", 32'(all_up), 32'd1);
    link_in[2] = 1'b0;
    n = 0;
    while (n < 200 && ch_reset[2] !== 1'b1) begin tick(); n++; end
    check("t6_rst_seen", 32'(ch_reset[2]), 32'd1);
    repeat (2) tick();
    apply_reset_now();
    check("t6_async_ch_reset", 32'(ch_reset), 32'd0);
    check("t6_async_sleds", 32'(sleds), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      hb_bits[j] = sleds[LEDS-1];
    end
    check("t6_heartbeat_restart", 32'(hb_bits), 32'hF0);

    // Randomized phase with an asynchronous reset in the middle.
    for (int c = 0; c < SFP; c++) hold[c] = 0;
    for (int i = 0; i < 1200; i++) begin
      for (int c = 0; c < SFP; c++) begin
        if (hold[c] == 0) begin
          link_in[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 90))
                                                 : int'($urandom_range(1, 20));
        end else begin
          hold[c]--;
        end
      end
      clr = ($urandom_range(0, 39) == 0);
      if (i == 600) begin
        apply_reset_now();
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
